alu_arbiter: RTL

- Shares one combinational `alu` instance between two requesters (req0, req1) using a valid/ready request handshake and a single tagged response channel.
- Arbitration is round-robin. Operands and opcode are registered before the ALU, and the result is registered after it.
- Sits between instruction-issue logic (or two independent masters) and the ALU datapath. Only one operation is in flight at a time.

---
 rtl/alu_arbiter_pkg.sv | 34 +++
 rtl/alu.sv | 28 ++
 rtl/alu_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU widths, opcodes and arbiter FSM encodings; also the latched-request record.
// Combinational helpers only, so there is no latency and no backpressure here.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ALU_OPRN_WIDTH = 6;
    localparam int unsigned ALU_OPRN_MAX = 9;

    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHR = 6'h04;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHL = 6'h05;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h09;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_EXEC = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     op1;
        logic [DATA_WIDTH-1:0]     op2;
        logic [ALU_OPRN_WIDTH-1:0] oprn;
        logic                      id;
    } arb_req_t;

    function automatic logic oprn_illegal(input logic [ALU_OPRN_WIDTH-1:0] oprn);
        return (oprn == '0) || (oprn > ALU_OPRN_WIDTH'(ALU_OPRN_MAX));
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU, opcodes 0x01-0x09; unknown opcodes give zero.
// Zero latency, no handshake: the result follows the inputs within the cycle.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]     i_op1,
    input  logic [DATA_WIDTH-1:0]     i_op2,
    input  logic [ALU_OPRN_WIDTH-1:0] i_oprn,
    output logic [DATA_WIDTH-1:0]     o_result
);

    always_comb begin
        o_result = '0;
        case (i_oprn)
            ALU_OPRN_ADD: o_result = i_op1 + i_op2;
            ALU_OPRN_SUB: o_result = i_op1 - i_op2;
            ALU_OPRN_MUL: o_result = i_op1 * i_op2;
            ALU_OPRN_SHR: o_result = i_op1 >> i_op2;
            ALU_OPRN_SHL: o_result = i_op1 << i_op2;
            ALU_OPRN_AND: o_result = i_op1 & i_op2;
            ALU_OPRN_OR:  o_result = i_op1 | i_op2;
            ALU_OPRN_NOR: o_result = ~(i_op1 | i_op2);
            ALU_OPRN_SLT: o_result = (i_op1 < i_op2) ? DATA_WIDTH'(1) : '0;
            default:      o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; accept at edge N, rsp_valid after N+1.
// One op in flight; while the response waits on rsp_ready no request is granted.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [OPRN_WIDTH-1:0] req0_oprn,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [OPRN_WIDTH-1:0] req1_oprn,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    import alu_arbiter_pkg::*;

    logic [1:0]            r_state;
    arb_req_t              r_req;
    logic                  r_last_grant;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_id;
    logic                  r_rsp_err;
    logic [CNT_WIDTH-1:0]  r_op_count;

    logic                  w_idle;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_illegal;
    arb_req_t              w_sel_req;
    logic [DATA_WIDTH-1:0] w_alu_result;

    // On a tie the requester that did not win last time gets the grant.
    assign w_idle    = (r_state == ARB_IDLE) && !RST;
    assign w_grant0  = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1  = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_illegal = oprn_illegal(r_req.oprn);

    always_comb begin
        w_sel_req = '{op1: req0_op1, op2: req0_op2, oprn: req0_oprn, id: 1'b0};
        if (w_grant1) begin
            w_sel_req = '{op1: req1_op1, op2: req1_op2, oprn: req1_oprn, id: 1'b1};
        end
    end

    alu u_alu (
        .i_op1    (r_req.op1),
        .i_op2    (r_req.op2),
        .i_oprn   (r_req.oprn),
        .o_result (w_alu_result)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ARB_IDLE;
            r_req        <= '0;
            r_last_grant <= 1'b1;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_req        <= w_sel_req;
                        r_last_grant <= w_sel_req.id;
                        r_state      <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    r_rsp_data <= w_illegal ? '0 : w_alu_result;
                    r_rsp_err  <= w_illegal;
                    r_rsp_id   <= r_req.id;
                    r_state    <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ARB_IDLE;
                        if (r_op_count != '1) begin
                            r_op_count <= r_op_count + 1'b1;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (r_state == ARB_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != ARB_IDLE);
    assign op_count   = r_op_count;

endmodule
